// File: rtl/modular_inverse_if.sv
// ---------------------------------------------------------------------------
// modular_inverse_if
//   Start/done handshake between the arithmetic-core controller and the
//   modular inverter.
//
//   Signals
//     start       controller -> inverter  request, accepted only when busy==0
//     a           controller -> inverter  operand, sampled on accepted start
//     modulant    controller -> inverter  modulus n (odd, >= 3 to be legal)
//     busy        inverter -> controller  operation in flight (incl. done cycle)
//     done        inverter -> controller  one-cycle pulse, results valid
//     result      inverter -> controller  a^-1 mod n, 0 on no_inverse/error
//     no_inverse  inverter -> controller  gcd(a, n) != 1
//     error       inverter -> controller  illegal modulus (even or < 3)
//
//   Modports
//     master  controller side
//     slave   inverter side
// ---------------------------------------------------------------------------
interface modular_inverse_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic                  start;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] modulant;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;
    logic                  no_inverse;
    logic                  error;

    modport master (
        output start, a, modulant,
        input  busy, done, result, no_inverse, error
    );

    modport slave (
        input  start, a, modulant,
        output busy, done, result, no_inverse, error
    );

endinterface

// File: rtl/modular_inverse.sv
// ---------------------------------------------------------------------------
// modular_inverse
//   Sequential modular inverter: result = a^-1 mod n using the binary
//   extended Euclidean algorithm, one loop step per clock.
//
//   Ports
//     clk    rising-edge clock
//     reset  synchronous, active-high; aborts any operation in flight
//     bus    modular_inverse_if.slave (start/a/modulant in,
//            busy/done/result/no_inverse/error out)
//
//   Operation
//     IDLE   -> accept start (busy==0), latch a and n
//     CHECK  -> reject even or < 3 modulus, skip REDUCE when a < n
//     REDUCE -> subtract n from u until u < n
//     LOOP   -> binary extended Euclid; invariants x1*a == u and
//               x2*a == v (mod n), x1/x2 kept in [0, n-1]
//     FINISH -> raise done for the following cycle, return to IDLE
//
//   Latency from the accept edge to done: 1 + floor(a/n) + loop steps + 1.
// ---------------------------------------------------------------------------
module modular_inverse #(
    parameter int DATA_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    modular_inverse_if.slave  bus
);

    localparam int W = DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REDUCE,
        LOOP,
        FINISH
    } state_t;

    state_t       state;
    logic [W-1:0] n_q;
    logic [W-1:0] u;
    logic [W-1:0] v;
    logic [W-1:0] x1;
    logic [W-1:0] x2;

    logic         busy_q;
    logic         done_q;
    logic [W-1:0] result_q;
    logic         no_inverse_q;
    logic         error_q;

    // Next-value helpers for the LOOP datapath. Sums that may exceed the
    // modulus are formed one bit wider so the carry is not lost.
    logic [W:0]   x1_plus_n;
    logic [W:0]   x2_plus_n;
    logic [W-1:0] x1_half;
    logic [W-1:0] x2_half;
    logic [W:0]   x1_wrap_diff;
    logic [W:0]   x2_wrap_diff;
    logic [W-1:0] x1_sub;
    logic [W-1:0] x2_sub;
    logic [W-1:0] u_minus_n;

    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        x1_plus_n    = {1'b0, x1} + {1'b0, n_q};
        x2_plus_n    = {1'b0, x2} + {1'b0, n_q};
        x1_half      = x1 >> 1;
        x2_half      = x2 >> 1;
        x1_wrap_diff = x1_plus_n - {1'b0, x2};
        x2_wrap_diff = x2_plus_n - {1'b0, x1};
        x1_sub       = x1 - x2;
        x2_sub       = x2 - x1;
        u_minus_n    = u - n_q;

        // Halving mod n: an odd value is made even by adding n (n is odd).
        if (x1[0]) x1_half = x1_plus_n[W:1];
        if (x2[0]) x2_half = x2_plus_n[W:1];

        // Subtraction mod n: wrap through n when the difference goes negative.
        if (x1 < x2) x1_sub = x1_wrap_diff[W-1:0];
        if (x2 < x1) x2_sub = x2_wrap_diff[W-1:0];
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            n_q          <= '0;
            u            <= '0;
            v            <= '0;
            x1           <= '0;
            x2           <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            no_inverse_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // busy is still high during the done cycle, so a start
                    // arriving then is dropped here.
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (bus.start && !busy_q) begin
                        n_q          <= bus.modulant;
                        u            <= bus.a;
                        v            <= bus.modulant;
                        x1           <= W'(1);
                        x2           <= '0;
                        busy_q       <= 1'b1;
                        result_q     <= '0;
                        no_inverse_q <= 1'b0;
                        error_q      <= 1'b0;
                        state        <= CHECK;
                    end
                end

                CHECK: begin
                    if (!n_q[0] || n_q < W'(3)) begin
                        error_q <= 1'b1;
                        state   <= FINISH;
                    end else if (u >= n_q) begin
                        state <= REDUCE;
                    end else begin
                        state <= LOOP;
                    end
                end

                REDUCE: begin
                    // Leave on the same cycle as the last subtraction so the
                    // state costs exactly floor(a/n) cycles.
                    u <= u_minus_n;
                    if (u_minus_n < n_q) state <= LOOP;
                end

                LOOP: begin
                    if (u == '0 || v == '0) begin
                        no_inverse_q <= 1'b1;
                        state        <= FINISH;
                    end else if (u == W'(1)) begin
                        result_q <= x1;
                        state    <= FINISH;
                    end else if (v == W'(1)) begin
                        result_q <= x2;
                        state    <= FINISH;
                    end else if (!u[0]) begin
                        u  <= u >> 1;
                        x1 <= x1_half;
                    end else if (!v[0]) begin
                        v  <= v >> 1;
                        x2 <= x2_half;
                    end else if (u >= v) begin
                        u  <= u - v;
                        x1 <= x1_sub;
                    end else begin
                        v  <= v - u;
                        x2 <= x2_sub;
                    end
                end

                FINISH: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b1;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.result     = result_q;
    assign bus.no_inverse = no_inverse_q;
    assign bus.error      = error_q;

endmodule
